// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter
package mem_arb_pkg;
  localparam int XLEN = 64;
  localparam int DW_BYTES = XLEN / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic                we;
    logic [DW_BYTES-1:0] wstrb;
    logic [XLEN-1:0]     wdata;
  } mem_req_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: data-priority grant with a saturating fetch-starvation counter
module arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  input  logic grant_fire,
  output logic grant_i,
  output logic grant_d
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic starved;
  assign starved = starve_cnt == CW'(STARVE_LIMIT);
  assign grant_i = grant_fire & i_valid & (~d_valid | starved);
  assign grant_d = grant_fire & d_valid & ~grant_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve_cnt <= '0;
    else if (grant_i) starve_cnt <= '0;
    else if (grant_d && i_valid && !starved) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int XLEN = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_rsp_valid,
  output logic [31:0]     i_rdata,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [XLEN-1:0] d_addr,
  input  logic            d_we,
  input  logic [7:0]      d_wstrb,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_rsp_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            m_req_valid,
  input  logic            m_req_ready,
  output logic [XLEN-1:0] m_addr,
  output logic            m_we,
  output logic [7:0]      m_wstrb,
  output logic [XLEN-1:0] m_wdata,
  input  logic            m_rsp_valid,
  input  logic [XLEN-1:0] m_rdata,
  output logic            busy
);
  import mem_arb_pkg::*;
  arb_state_t state, state_n;
  owner_t owner;
  mem_req_t req_q;
  logic [XLEN-1:0] rdata_q;
  logic grant_i, grant_d;
  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk(clk),
    .rst(rst),
    .i_valid(i_req_valid),
    .d_valid(d_req_valid),
    .grant_fire(state == IDLE),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && (grant_i || grant_d)) ? ISSUE :
              (state == ISSUE && m_req_ready) ? WAIT :
              (state == WAIT && m_rsp_valid) ? RESP :
              (state == RESP) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      owner   <= OWN_I;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      busy  <= state_n != IDLE;
      if (grant_i || grant_d) begin
        owner <= grant_i ? OWN_I : OWN_D;
        req_q <= grant_i ? mem_req_t'{addr: i_addr, we: 1'b0, wstrb: '0, wdata: '0}
                         : mem_req_t'{addr: d_addr, we: d_we, wstrb: d_wstrb, wdata: d_wdata};
      end
      if (state == WAIT && m_rsp_valid) rdata_q <= m_rdata;
    end
  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;
  assign m_req_valid = state == ISSUE;
  assign m_addr      = {req_q.addr[XLEN-1:3], 3'b000};
  assign m_we        = req_q.we;
  assign m_wstrb     = req_q.wstrb;
  assign m_wdata     = req_q.wdata;
  assign i_rsp_valid = state == RESP && owner == OWN_I;
  assign d_rsp_valid = state == RESP && owner == OWN_D;
  assign i_rdata     = req_q.addr[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign d_rdata     = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic i_req_valid, i_req_ready, i_rsp_valid;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0] d_wstrb, m_wstrb;
  logic m_req_valid, m_req_ready, m_we, m_rsp_valid, busy;
  logic [63:0] m_addr, m_wdata, m_rdata;
  int checks = 0;
  int errors = 0;
  logic [63:0] mem_q;
  logic [9:0] seq;
  mem_port_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_we(m_we), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit exp_i, input logic [63:0] exp_maddr, input logic [63:0] rd,
                     input int bp, input bit hold);
    #1;
    chk("accept_i_ready", i_req_ready, exp_i);
    chk("accept_d_ready", d_req_ready, !exp_i);
    m_req_ready = (bp == 0);
    @(negedge clk);
    if (!hold) begin
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
    end
    #1;
    chk("issue_m_req_valid", m_req_valid, 1'b1);
    chk("issue_m_addr", m_addr, exp_maddr);
    chk("issue_busy", busy, 1'b1);
    chk("issue_no_ready", {i_req_ready, d_req_ready}, 2'b00);
    for (int k = 0; k < bp; k++) begin
      i_req_valid = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_m_req_valid", m_req_valid, 1'b1);
      chk("bp_m_addr", m_addr, exp_maddr);
      chk("bp_m_wdata", m_wdata, mem_q);
      chk("bp_busy", busy, 1'b1);
      chk("bp_no_ready", {i_req_ready, d_req_ready}, 2'b00);
    end
    if (bp > 0) i_req_valid = 1'b0;
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("wait_m_req_valid", m_req_valid, 1'b0);
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    m_rsp_valid = 1'b0;
    chk("resp_i_rsp_valid", i_rsp_valid, exp_i);
    chk("resp_d_rsp_valid", d_rsp_valid, !exp_i);
  endtask
  initial begin
    rst = 1'b0;
    i_req_valid = 0; i_addr = 0;
    d_req_valid = 0; d_addr = 0; d_we = 0; d_wstrb = 0; d_wdata = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rdata = 0;
    mem_q = 64'h0;
    #1;
    chk("rst_outputs", {i_rsp_valid, d_rsp_valid, m_req_valid, m_we, busy}, 5'b0);
    chk("rst_m_wstrb", m_wstrb, 8'h00);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_d_rdata", d_rdata, 64'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // fetch only, upper word of the doubleword
    i_req_valid = 1'b1; i_addr = 64'h1004;
    txn(1'b1, 64'h1000, 64'hAABBCCDD_11223344, 0, 1'b0);
    chk("fetch_i_rdata", i_rdata, 32'hAABBCCDD);
    @(negedge clk);
    chk("fetch_done_rsp", {i_rsp_valid, d_rsp_valid}, 2'b00);
    chk("fetch_done_busy", busy, 1'b0);
    // store
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wstrb = 8'h0F;
    d_wdata = 64'h00000000_DEADBEEF;
    txn(1'b0, 64'h2000, 64'h0, 0, 1'b0);
    chk("store_m_we", m_we, 1'b1);
    chk("store_m_wstrb", m_wstrb, 8'h0F);
    chk("store_m_wdata", m_wdata, 64'h00000000_DEADBEEF);
    mem_q = 64'h00000000_DEADBEEF;
    @(negedge clk);
    // load back
    d_req_valid = 1'b1; d_we = 1'b0; d_wstrb = 8'h00; d_wdata = 64'h0;
    txn(1'b0, 64'h2000, mem_q, 0, 1'b0);
    chk("load_d_rdata", d_rdata, 64'h00000000_DEADBEEF);
    chk("load_m_we", m_we, 1'b0);
    @(negedge clk);
    // contention with both requesters always valid
    seq = 10'b1000010000;
    i_req_valid = 1'b1; i_addr = 64'h3000;
    d_req_valid = 1'b1; d_addr = 64'h4000;
    for (int k = 0; k < 10; k++) begin
      txn(seq[k], seq[k] ? 64'h3000 : 64'h4000, 64'h0, 0, 1'b1);
      @(negedge clk);
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    // memory backpressure on a store
    d_req_valid = 1'b1; d_we = 1'b1; d_addr = 64'h5008; d_wstrb = 8'hF0;
    d_wdata = 64'h12345678_00000000;
    mem_q = 64'h12345678_00000000;
    txn(1'b0, 64'h5008, 64'h0, 5, 1'b0);
    d_we = 1'b0; d_wstrb = 8'h00; d_wdata = 64'h0;
    @(negedge clk);
    // reset while in WAIT
    i_req_valid = 1'b1; i_addr = 64'h6000; m_req_ready = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait_m_req_valid", m_req_valid, 1'b0);
    chk("pre_rst_wait_busy", busy, 1'b1);
    m_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_wait_busy", busy, 1'b0);
    chk("rst_wait_m_addr", m_addr, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_rsp_valid = 1'b1; m_rdata = 64'hFFFF0000_FFFF0000;
    @(negedge clk);
    m_rsp_valid = 1'b0;
    chk("late_rsp_no_rsp", {i_rsp_valid, d_rsp_valid}, 2'b00);
    chk("late_rsp_busy", busy, 1'b0);
    chk("late_rsp_d_rdata", d_rdata, 64'h0);
    mem_q = 64'h0;
    i_req_valid = 1'b1; i_addr = 64'h7000;
    txn(1'b1, 64'h7000, 64'h01020304_A5A5C3C3, 0, 1'b0);
    chk("post_rst_i_rdata", i_rdata, 32'hA5A5C3C3);
    @(negedge clk);
    // spurious response in IDLE
    m_rsp_valid = 1'b1; m_rdata = 64'hDEAD0000_BEEF0000;
    @(negedge clk);
    m_rsp_valid = 1'b0;
    chk("spur_rsp", {i_rsp_valid, d_rsp_valid, m_req_valid, busy}, 4'b0000);
    chk("spur_i_rdata", i_rdata, 32'hA5A5C3C3);
    chk("spur_d_rdata", d_rdata, 64'h01020304_A5A5C3C3);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
